// File: rtl/video_mode_sequencer_pkg.sv
// Shared types for the video mode sequencer: mode-select codes, timing records,
// profile indices and FSM states (ST_ERROR exists only with MODE_SWITCH_TIMEOUT_EN).
`ifndef VIDEO_MODE_SEQUENCER_CODES
`define VIDEO_MODE_SEQUENCER_CODES
`define MODE_1080p 8'h01
`define MODE_1080i 8'h02
`define MODE_720p  8'h03
`define MODE_480p  8'h04
`define MODE_480i  8'h05
`endif

package video_mode_sequencer_pkg;

  typedef struct packed {
    logic [11:0] h_active;
    logic [11:0] v_active;
    logic [11:0] h_total;
    logic [11:0] v_total;
    logic        interlaced;
  } VideoMode;

  localparam VideoMode VIDEO_MODE_1080P = '{h_active: 12'd1920, v_active: 12'd1080,
                                            h_total: 12'd2200, v_total: 12'd1125, interlaced: 1'b0};
  localparam VideoMode VIDEO_MODE_1080I = '{h_active: 12'd1920, v_active: 12'd1080,
                                            h_total: 12'd2200, v_total: 12'd1125, interlaced: 1'b1};
  localparam VideoMode VIDEO_MODE_720P  = '{h_active: 12'd1280, v_active: 12'd720,
                                            h_total: 12'd1650, v_total: 12'd750,  interlaced: 1'b0};
  localparam VideoMode VIDEO_MODE_480P  = '{h_active: 12'd720,  v_active: 12'd480,
                                            h_total: 12'd858,  v_total: 12'd525,  interlaced: 1'b0};
  localparam VideoMode VIDEO_MODE_480I  = '{h_active: 12'd720,  v_active: 12'd480,
                                            h_total: 12'd858,  v_total: 12'd525,  interlaced: 1'b1};

  localparam logic [7:0] MODE_SEL_1080P = `MODE_1080p;
  localparam logic [7:0] MODE_SEL_1080I = `MODE_1080i;
  localparam logic [7:0] MODE_SEL_720P  = `MODE_720p;
  localparam logic [7:0] MODE_SEL_480P  = `MODE_480p;
  localparam logic [7:0] MODE_SEL_480I  = `MODE_480i;

  localparam logic [2:0] MODE_IDX_1080P = 3'd0;
  localparam logic [2:0] MODE_IDX_1080I = 3'd1;
  localparam logic [2:0] MODE_IDX_720P  = 3'd2;
  localparam logic [2:0] MODE_IDX_480P  = 3'd3;
  localparam logic [2:0] MODE_IDX_480I  = 3'd4;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_DEBOUNCE  = 3'd1,
    ST_BLANK     = 3'd2,
    ST_RECONF    = 3'd3,
    ST_WAIT_BUSY = 3'd4,
    ST_WAIT_LOCK = 3'd5
`ifdef MODE_SWITCH_TIMEOUT_EN
    ,ST_ERROR    = 3'd6
`endif
  } seq_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/video_mode_sequencer_decode.sv
// Combinational decode of the 8-bit mode-select code into validity, PLL profile
// index and timing record.
module video_mode_decode
  import video_mode_sequencer_pkg::*;
(
  input  logic [7:0] i_mode_sel,
  output logic       o_valid,
  output logic [2:0] o_mode_idx,
  output VideoMode   o_mode
);

  // Code lookup; unknown codes decode as invalid
  always_comb begin
    o_valid    = 1'b1;
    o_mode_idx = MODE_IDX_1080P;
    o_mode     = VIDEO_MODE_1080P;
    case (i_mode_sel)
      MODE_SEL_1080P: begin
        o_mode_idx = MODE_IDX_1080P;
        o_mode     = VIDEO_MODE_1080P;
      end
      MODE_SEL_1080I: begin
        o_mode_idx = MODE_IDX_1080I;
        o_mode     = VIDEO_MODE_1080I;
      end
      MODE_SEL_720P: begin
        o_mode_idx = MODE_IDX_720P;
        o_mode     = VIDEO_MODE_720P;
      end
      MODE_SEL_480P: begin
        o_mode_idx = MODE_IDX_480P;
        o_mode     = VIDEO_MODE_480P;
      end
      MODE_SEL_480I: begin
        o_mode_idx = MODE_IDX_480I;
        o_mode     = VIDEO_MODE_480I;
      end
      default: begin
        o_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/video_mode_sequencer.sv
// Run-time video mode switch controller: debounce, blank, PLL reconfig, settle.
// MODE_SWITCH_TIMEOUT_EN adds reconfig retries, lock timeouts and the ERROR state.
module video_mode_sequencer
  import video_mode_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned BLANK_CYCLES    = 256,
  parameter int unsigned SETTLE_CYCLES   = 4096,
  parameter int unsigned LOCK_TIMEOUT    = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] mode_sel,
  input  logic       pll_reconf_busy,
  input  logic       pll_locked,
  output logic       pll_reconf_start,
  output logic [2:0] mode_index,
  output VideoMode   videoMode,
  output logic       video_enable,
  output logic       mode_changed,
  output logic       error
);

  localparam int unsigned CNT_W = $clog2(max3(DEBOUNCE_CYCLES, BLANK_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_e       r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [2:0]       r_cand_idx, w_cand_next;
  logic [2:0]       r_tgt_idx;
  VideoMode         r_tgt_mode;
  logic             r_busy_seen, w_busy_seen_next;
  logic             r_reconf_path;
  logic             w_latch_tgt;
  logic             w_valid;
  logic [2:0]       w_idx;
  VideoMode         w_mode;
  logic             w_retry_any;
  logic             w_req;
  logic             w_timeout;
  logic             w_to_retry;
  seq_state_e       w_abort_state;
  seq_state_e       w_fail_state;

  video_mode_decode u_decode (
    .i_mode_sel (mode_sel),
    .o_valid    (w_valid),
    .o_mode_idx (w_idx),
    .o_mode     (w_mode)
  );

`ifdef MODE_SWITCH_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic [1:0]      r_attempt;
  logic            r_error;
  logic            w_to_active;

  assign w_to_active   = (r_state == ST_RECONF) || (r_state == ST_WAIT_BUSY) ||
                         (r_state == ST_WAIT_LOCK);
  assign w_timeout     = w_to_active && (r_to_cnt == TO_LAST);
  assign w_to_retry    = r_reconf_path && (r_attempt != 2'd2);
  // While in error any valid code (even the current one) may trigger a retry
  assign w_retry_any   = r_error;
  assign w_abort_state = r_error ? ST_ERROR : ST_RUN;
  assign w_fail_state  = ST_ERROR;
  assign error         = r_error;

  // Timeout counter, attempt count and sticky error flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_to_cnt  <= '0;
      r_attempt <= 2'd0;
      r_error   <= 1'b0;
    end else begin
      if ((w_next == ST_RECONF) || !w_to_active) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (w_next == ST_BLANK) begin
        r_attempt <= 2'd0;
      end else if (w_timeout && (w_next == ST_RECONF)) begin
        r_attempt <= r_attempt + 2'd1;
      end
      if (w_next == ST_BLANK) begin
        r_error <= 1'b0;
      end else if (w_next == ST_ERROR) begin
        r_error <= 1'b1;
      end
    end
  end
`else
  logic w_unused_lock_timeout;
  assign w_unused_lock_timeout = (LOCK_TIMEOUT != 32'd0);
  assign w_timeout     = 1'b0;
  assign w_to_retry    = 1'b0;
  assign w_retry_any   = 1'b0;
  assign w_abort_state = ST_RUN;
  assign w_fail_state  = ST_BLANK;
  assign error         = 1'b0;
`endif

  assign w_req = w_valid && (w_retry_any || (w_idx != mode_index));

  // Next-state and working-register updates
  always_comb begin
    w_next           = r_state;
    w_cnt_next       = r_cnt;
    w_cand_next      = r_cand_idx;
    w_busy_seen_next = r_busy_seen;
    w_latch_tgt      = 1'b0;
    if (w_timeout) begin
      w_cnt_next = '0;
      if (w_to_retry) begin
        w_next = ST_RECONF;
      end else begin
        w_next = w_fail_state;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          w_cnt_next = '0;
          if (!pll_locked) begin
            w_next = ST_WAIT_LOCK;
          end else if (w_req) begin
            w_next      = ST_DEBOUNCE;
            w_cand_next = w_idx;
          end else begin
            w_next = ST_RUN;
          end
        end
        ST_DEBOUNCE: begin
          if (!w_req) begin
            w_next     = w_abort_state;
            w_cnt_next = '0;
          end else if (w_idx != r_cand_idx) begin
            w_cand_next = w_idx;
            w_cnt_next  = '0;
          end else if (r_cnt == DEB_LAST) begin
            w_next      = ST_BLANK;
            w_cnt_next  = '0;
            w_latch_tgt = 1'b1;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_next     = ST_RECONF;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        ST_RECONF: begin
          w_next           = ST_WAIT_BUSY;
          w_cnt_next       = '0;
          w_busy_seen_next = 1'b0;
        end
        ST_WAIT_BUSY: begin
          if (pll_reconf_busy) begin
            w_busy_seen_next = 1'b1;
          end else if (r_busy_seen) begin
            w_next     = ST_WAIT_LOCK;
            w_cnt_next = '0;
          end else begin
            w_next = ST_WAIT_BUSY;
          end
        end
        ST_WAIT_LOCK: begin
          if (!pll_locked) begin
            w_cnt_next = '0;
          end else if (r_cnt == SETTLE_LAST) begin
            w_next     = ST_RUN;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
`ifdef MODE_SWITCH_TIMEOUT_EN
        ST_ERROR: begin
          w_cnt_next = '0;
          if (w_valid) begin
            w_next      = ST_DEBOUNCE;
            w_cand_next = w_idx;
          end else begin
            w_next = ST_ERROR;
          end
        end
`endif
        default: begin
          w_next     = ST_BLANK;
          w_cnt_next = '0;
        end
      endcase
    end
  end

  // State, counters and target latch; reset forces a full 1080p reconfiguration
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_BLANK;
      r_cnt         <= '0;
      r_cand_idx    <= MODE_IDX_1080P;
      r_tgt_idx     <= MODE_IDX_1080P;
      r_tgt_mode    <= VIDEO_MODE_1080P;
      r_busy_seen   <= 1'b0;
      r_reconf_path <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_cand_idx  <= w_cand_next;
      r_busy_seen <= w_busy_seen_next;
      if (w_latch_tgt) begin
        r_tgt_idx  <= w_idx;
        r_tgt_mode <= w_mode;
      end
      if (w_next == ST_RECONF) begin
        r_reconf_path <= 1'b1;
      end else if (w_next == ST_RUN) begin
        r_reconf_path <= 1'b0;
      end
    end
  end

  // Outputs are registered from the state being entered so they align with it
  always_ff @(posedge clock) begin
    if (reset) begin
      pll_reconf_start <= 1'b0;
      video_enable     <= 1'b0;
      mode_changed     <= 1'b0;
      mode_index       <= MODE_IDX_1080P;
      videoMode        <= VIDEO_MODE_1080P;
    end else begin
      pll_reconf_start <= (w_next == ST_RECONF);
      video_enable     <= (w_next == ST_RUN) || ((w_next == ST_DEBOUNCE) && video_enable);
      mode_changed     <= (w_next == ST_RUN) && (r_state == ST_WAIT_LOCK) && r_reconf_path;
      if (w_next == ST_RECONF) begin
        mode_index <= r_tgt_idx;
        videoMode  <= r_tgt_mode;
      end
    end
  end

endmodule

// File: doc/video_mode_sequencer.md
# video_mode_sequencer

Controller that owns run-time video mode changes. It debounces the 8-bit mode-select input, blanks the video output, and triggers a pixel-clock PLL reconfiguration for the new mode. It then waits for PLL lock and settling before re-enabling video. It sits between the mode-select source and the timing generator / PLL reconfig block, and replaces direct mode latching.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 1024: consecutive stable cycles required before a new mode request is accepted.
- BLANK_CYCLES, default 256: cycles video stays blanked before reconfig starts.
- SETTLE_CYCLES, default 4096: consecutive cycles pll_locked must be high before video is enabled.
- LOCK_TIMEOUT, default 1000000: cycles allowed from reconfig start to settled lock. Used only with MODE_SWITCH_TIMEOUT_EN.

Ports (one clock; reset is synchronous and active-high):
- clock  in  1: system clock; all logic is on its rising edge.
- reset  in  1: synchronous, active-high reset.
- mode_sel  in  8: requested mode code (`MODE_1080p/1080i/720p/480p/480i); other codes are ignored.
- pll_reconf_busy  in  1: high while the PLL reconfig block works.
- pll_locked  in  1: pixel PLL lock indicator (already synchronised to clock).
- pll_reconf_start  out  1: single-cycle reconfig request.
- mode_index  out  3: PLL profile select (0 = 1080p, 1 = 1080i, 2 = 720p, 3 = 480p, 4 = 480i); stable from the start pulse until the next switch.
- videoMode  out  VideoMode: active timing record for the timing generator.
- video_enable  out  1: high only when the timing generator may drive output.
- mode_changed  out  1: single-cycle pulse on entry to RUN after a switch.
- error  out  1: switch failed (timeout build only).

## Operation
- Reset values: video_enable = 0, pll_reconf_start = 0, mode_changed = 0, error = 0, mode_index = 0, videoMode = VIDEO_MODE_1080P.
- After reset, the FSM enters BLANK with target = 1080p, so it always performs one full reconfiguration.
- States:
  - RUN: video_enable = 1. When mode_sel is valid and differs from the current mode, go to DEBOUNCE with cnt = 0. When pll_locked falls, go to WAIT_LOCK; there is no reconfig and the mode is unchanged.
  - DEBOUNCE: video_enable stays 1. If mode_sel changes to another valid, non-current code, cnt restarts and that code becomes the candidate. If mode_sel equals the current mode or is invalid, return to RUN. When cnt reaches DEBOUNCE_CYCLES−1 with the input stable, latch the target and go to BLANK.
  - BLANK: video_enable = 0 for BLANK_CYCLES cycles, then go to RECONF.
  - RECONF: one cycle. pll_reconf_start = 1; mode_index and videoMode update to the target in this same cycle. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for pll_reconf_busy to rise, then fall, then go to WAIT_LOCK. A busy level that is already high counts as the rise.
  - WAIT_LOCK: count consecutive pll_locked cycles; a low level resets the count. At SETTLE_CYCLES go to RUN and pulse mode_changed, but only when the path included RECONF.
  - ERROR (timeout build only): video_enable = 0, error = 1. Exit only on a debounced valid request, which goes via DEBOUNCE to BLANK and clears error at BLANK entry.
- mode_sel is ignored in BLANK, RECONF, WAIT_BUSY and WAIT_LOCK. A pending difference is re-detected in RUN and debounced afresh.
- reset in any state aborts immediately to the reset values; a partial reconfig is simply restarted.

## Timing
- Minimum request-to-enable time: DEBOUNCE_CYCLES + BLANK_CYCLES + 1 + busy duration + SETTLE_CYCLES cycles.
- video_enable falls in the first BLANK cycle and rises in the first RUN cycle.
- mode_changed is asserted in the same cycle that video_enable rises.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- MODE_SWITCH_TIMEOUT_EN defined:
  - A timeout counter runs from RECONF through WAIT_LOCK.
  - On reaching LOCK_TIMEOUT, the FSM re-enters RECONF, up to 3 attempts in total.
  - If the third attempt also times out, the FSM goes to ERROR.
  - A lock loss in RUN that is not restored within LOCK_TIMEOUT also goes to ERROR.
- MODE_SWITCH_TIMEOUT_EN undefined:
  - The FSM waits indefinitely and the ERROR state does not exist.
  - error is tied to 0 and the LOCK_TIMEOUT parameter is unused.

## Structure
- Shared package:
  - VideoMode typedef and VIDEO_MODE_* constants (existing).
  - A new state enum.
  - Mode-index constants MODE_IDX_1080P..MODE_IDX_480I.
- Sub-module video_mode_decode (combinational): mode_sel → {valid, mode_index, VideoMode}. It is shared by the DEBOUNCE comparison and the target latch.

## Test plan
Bench parameters: DEBOUNCE = 4, BLANK = 3, SETTLE = 5, LOCK_TIMEOUT = 50, busy modelled as 6 cycles.
- Reset, pll_locked held high → one reconf_start with mode_index = 0; video_enable = 1 after the full sequence; mode_changed pulses once.
- From 1080p, mode_sel = `MODE_720p for 4+ cycles → blank, start pulse, mode_index = 2, videoMode = 720P; enable returns after busy + 5 locked cycles.
- mode_sel toggles 720p → 480p after 2 cycles → debounce restarts; final mode_index = 3; exactly one start pulse.
- Invalid code 8'hFF, or a glitch shorter than 4 cycles → no state change; video_enable stays 1.
- pll_locked drops for 2 cycles in RUN → video_enable low, no start pulse, re-enabled after 5 locked cycles, no mode_changed pulse.
- Timeout build, pll_locked never rises → 3 start pulses spaced ≤50 cycles apart, then error = 1 and video_enable = 0; a new valid request clears error.
